// File: rtl/cic_dec_ctrl.sv
// rtl/cic_dec_ctrl.sv - CIC decimator sequencer, settle discard, shift/saturate scaler and FWFT output FIFO
// Optional round-half-up scaling via CIC_DEC_CTRL_ROUND_EN.
module cic_dec_ctrl #(
  parameter int IN_W       = 35,
  parameter int OUT_W      = 16,
  parameter int SETTLE_N   = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [5:0]              shift_cfg,
  input  logic signed [IN_W-1:0]  cic_dat,
  input  logic                    cic_vld,
  output logic                    cic_rstn,
  output logic [OUT_W-1:0]        m_dat,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    ovf,
  output logic                    sat,
  input  logic                    clr_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SETTLE_N + 1);
  localparam logic [5:0] MAX_SHIFT = 6'(IN_W - 1);
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MIN_V = -MAX_V - (IN_W+1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [5:0]             shift_reg;
  logic [CW-1:0]          settle_cnt;

  logic                   cap_vld;
  logic signed [IN_W-1:0] cap_dat;
  logic                   sc_vld;
  logic [OUT_W-1:0]       sc_dat;

  logic [OUT_W-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;

  logic signed [IN_W:0]   sc_sum;
  logic signed [IN_W:0]   sc_y;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [OUT_W-1:0]       sc_q;
  logic                   full;
  logic                   pop;
  logic                   do_push;
  logic                   ovf_set;
  logic                   sat_set;
  logic                   pipe_idle;

  // Sum is one bit wider than the input so the rounding offset never wraps.
  always_comb begin
    sc_sum = {cap_dat[IN_W-1], cap_dat};
`ifdef CIC_DEC_CTRL_ROUND_EN
    if (shift_reg != 6'd0)
      sc_sum = sc_sum + ((IN_W+1)'(1) << (shift_reg - 6'd1));
`else
`endif
    sc_y   = sc_sum >>> shift_reg;
    sat_hi = sc_y > MAX_V;
    sat_lo = sc_y < MIN_V;
    if (sat_hi)
      sc_q = MAX_V[OUT_W-1:0];
    else if (sat_lo)
      sc_q = MIN_V[OUT_W-1:0];
    else
      sc_q = sc_y[OUT_W-1:0];
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign m_valid   = (count != '0);
  assign m_dat     = m_valid ? mem[rd_ptr] : '0;
  assign pop       = m_valid && m_ready;
  assign do_push   = sc_vld && (!full || pop);
  assign ovf_set   = sc_vld && full && !pop;
  assign sat_set   = cap_vld && (sat_hi || sat_lo);
  assign pipe_idle = !cap_vld && !sc_vld && (count == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      shift_reg  <= '0;
      settle_cnt <= '0;
      cic_rstn   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state      <= SETTLE;
            shift_reg  <= (shift_cfg > MAX_SHIFT) ? MAX_SHIFT : shift_cfg;
            settle_cnt <= '0;
            cic_rstn   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (!en) begin
            state    <= IDLE;
            cic_rstn <= 1'b0;
            busy     <= 1'b0;
          end else if (cic_vld) begin
            if (settle_cnt == CW'(SETTLE_N - 1))
              state <= RUN;
            else
              settle_cnt <= settle_cnt + CW'(1);
          end
        end
        RUN: begin
          if (!en)
            state <= DRAIN;
        end
        DRAIN: begin
          if (pipe_idle) begin
            state    <= IDLE;
            cic_rstn <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cic_rstn <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Capture, scale and push form a three-edge pipeline ahead of the FIFO head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_vld <= 1'b0;
      cap_dat <= '0;
      sc_vld  <= 1'b0;
      sc_dat  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      sat     <= 1'b0;
    end else begin
      cap_vld <= (state == RUN) && cic_vld;
      if ((state == RUN) && cic_vld)
        cap_dat <= cic_dat;
      sc_vld <= cap_vld;
      if (cap_vld)
        sc_dat <= sc_q;
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !do_push)
        count <= count - (AW+1)'(1);
      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_flags)
        ovf <= 1'b0;
      if (sat_set)
        sat <= 1'b1;
      else if (clr_flags)
        sat <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= sc_dat;
  end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb/tb_cic_dec_ctrl.sv - directed table-driven bench for cic_dec_ctrl
module tb_cic_dec_ctrl;

  logic               clk = 1'b0;
  logic               rstn;
  logic               en;
  logic [5:0]         shift_cfg;
  logic signed [34:0] cic_dat;
  logic               cic_vld;
  logic               cic_rstn;
  logic [15:0]        m_dat;
  logic               m_valid;
  logic               m_ready;
  logic               busy;
  logic               ovf;
  logic               sat;
  logic               clr_flags;

  int total = 0;
  int bad = 0;

  typedef struct {
    int     shift;
    longint dat;
    longint exp;
    bit     exp_sat;
  } vec_t;

  vec_t vt[9];

  cic_dec_ctrl dut (
    .clk(clk), .rstn(rstn), .en(en), .shift_cfg(shift_cfg),
    .cic_dat(cic_dat), .cic_vld(cic_vld), .cic_rstn(cic_rstn),
    .m_dat(m_dat), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .ovf(ovf), .sat(sat), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic strobe(input longint d);
    cic_dat = d[34:0];
    cic_vld = 1'b1;
    step();
    cic_vld = 1'b0;
    step();
  endtask

  task automatic start(input int s);
    en = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 50 && busy; i++) step();
    check("start_idle", busy, 0);
    shift_cfg = 6'(s);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) strobe(longint'(1000 + i));
  endtask

  initial begin
    longint got[$];
    int busy_low;
    vt[0] = '{19, 64'sd1835008, 3, 1'b0};
    vt[1] = '{19, -64'sd524289, -2, 1'b0};
    vt[2] = '{0, 64'sd17179869183, 32767, 1'b1};
    vt[3] = '{0, -64'sd17179869184, -32768, 1'b1};
    vt[4] = '{63, 64'sd17179869183, 0, 1'b0};
    vt[5] = '{63, -64'sd17179869184, -1, 1'b0};
    vt[6] = '{4, 64'sd104, 6, 1'b0};
    vt[7] = '{0, -64'sd32768, -32768, 1'b0};
    vt[8] = '{0, -64'sd32769, -32768, 1'b1};
`ifdef CIC_DEC_CTRL_ROUND_EN
    vt[0].exp = 4;
    vt[1].exp = -1;
    vt[4].exp = 1;
    vt[6].exp = 7;
`endif

    rstn = 1'b0; en = 1'b0; shift_cfg = '0; cic_dat = '0; cic_vld = 1'b0;
    m_ready = 1'b1; clr_flags = 1'b0;
    step(); step();
    check("rst_cic_rstn", cic_rstn, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_dat", m_dat, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sat", sat, 0);
    rstn = 1'b1;
    step();

    // Settle discard: strobes 1..5 dropped, 6..8 emitted.
    en = 1'b1;
    step();
    busy_low = 0;
    for (int k = 1; k <= 8; k++) begin
      cic_dat = 35'(k);
      cic_vld = 1'b1;
      step();
      cic_vld = 1'b0;
      for (int c = 0; c < 63; c++) begin
        if (m_valid) got.push_back(longint'($signed(m_dat)));
        if (!busy) busy_low++;
        step();
      end
    end
    check("settle_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++)
      check("settle_value", got[i], 6 + i);
    check("settle_busy_low", busy_low, 0);

    // Scaling and saturation vectors.
    for (int i = 0; i < 9; i++) begin
      start(vt[i].shift);
      strobe(vt[i].dat);
      for (int c = 0; c < 8 && !m_valid; c++) step();
      check($sformatf("vec%0d_valid", i), m_valid, 1);
      check($sformatf("vec%0d_dat", i), longint'($signed(m_dat)), vt[i].exp);
      check($sformatf("vec%0d_sat", i), sat, vt[i].exp_sat);
    end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("sat_clear", sat, 0);

    // Overflow: 10..13 held, 14 and 15 dropped.
    start(0);
    m_ready = 1'b0;
    for (int v = 10; v <= 15; v++) strobe(longint'(v));
    step(); step(); step();
    check("ovf_flag", ovf, 1);
    check("ovf_sat", sat, 0);
    m_ready = 1'b1;
    for (int v = 10; v <= 13; v++) begin
      check("ovf_pop_valid", m_valid, 1);
      check("ovf_pop_dat", longint'($signed(m_dat)), v);
      step();
    end
    check("ovf_empty", m_valid, 0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("ovf_clear", ovf, 0);

    // Drain and stop.
    m_ready = 1'b0;
    strobe(20);
    strobe(21);
    step(); step(); step();
    en = 1'b0;
    step();
    check("drain_busy", busy, 1);
    check("drain_cic_rstn", cic_rstn, 1);
    step(); step();
    check("drain_hold_busy", busy, 1);
    check("drain_hold_dat", longint'($signed(m_dat)), 20);
    m_ready = 1'b1;
    check("drain_pop0", longint'($signed(m_dat)), 20);
    step();
    check("drain_pop1", longint'($signed(m_dat)), 21);
    step();
    for (int c = 0; c < 10 && busy; c++) step();
    check("drain_idle_busy", busy, 0);
    check("drain_idle_cic_rstn", cic_rstn, 0);
    shift_cfg = '0;
    en = 1'b1;
    step();
    check("restart_busy", busy, 1);
    check("restart_cic_rstn", cic_rstn, 1);

    // Reset mid-operation with queued data and sat set.
    for (int i = 0; i < 5; i++) strobe(longint'(50 + i));
    m_ready = 1'b0;
    strobe(64'sd17179869183);
    step(); step(); step();
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_sat", sat, 1);
    #2;
    rstn = 1'b0;
    en = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_cic_rstn", cic_rstn, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_busy", busy, 0);
    step(); step();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_busy", busy, 0);
    check("post_rst_cic_rstn", cic_rstn, 0);
    check("post_rst_valid", m_valid, 0);
    en = 1'b1;
    step();
    check("post_rst_start", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
- Sequencer and output stage for the 5-stage CIC decimator, which has a fixed 64x decimation and a 35-bit output.
- Holds the filter in reset while disabled and releases it on enable.
- Discards the start-up transient outputs, then scales each output by a configurable right shift with saturation.
- Buffers samples in a small FIFO and presents them on a valid/ready stream to downstream DSP or the bus.

Parameters:
- IN_W, 35: CIC output width (signed).
- OUT_W, 16: output sample width (signed).
- SETTLE_N, 5: number of CIC output strobes discarded after release (equals filter order).
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  level enable; 1 = run, 0 = stop
- shift_cfg  in  6  right-shift amount; latched on IDLE->SETTLE
- cic_dat  in  IN_W  CIC filter dat_out
- cic_vld  in  1  CIC filter clk_vld_out (1-cycle strobe)
- cic_rstn  out  1  active-low reset driven to the CIC filter
- m_dat  out  OUT_W  output sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- ovf  out  1  sticky: sample dropped because the FIFO was full
- sat  out  1  sticky: a sample was saturated
- clr_flags  in  1  synchronous clear of ovf and sat

Behaviour:
Reset:
- State = IDLE.
- Outputs cleared: cic_rstn=0, m_valid=0, m_dat=0, busy=0, ovf=0, sat=0.
- FIFO empty, counters cleared.
- Reset takes effect immediately from any state; any FIFO contents are lost.

FSM (registered):
- IDLE:
  - cic_rstn=0.
  - en=1 -> SETTLE; shift_reg <= min(shift_cfg, IN_W-1); settle_cnt <= 0.
- SETTLE:
  - cic_rstn=1.
  - Each cic_vld increments settle_cnt; the sample is discarded.
  - When the SETTLE_N-th strobe is counted -> RUN. That strobe is also discarded.
  - en=0 -> IDLE immediately.
- RUN:
  - cic_rstn=1.
  - Each cic_vld captures cic_dat into the scale stage.
  - en=0 -> DRAIN. A sample already in the scale stage is still pushed.
- DRAIN:
  - cic_rstn=1; no new captures.
  - When the scale stage is idle and the FIFO is empty -> IDLE.
  - en is ignored until IDLE is reached.

Datapath:
- Scale stage, one registered cycle:
  - y = cic_dat >>> shift_reg (arithmetic shift, floor).
  - If y > 2^(OUT_W-1)-1, clamp to 2^(OUT_W-1)-1 and set sat.
  - If y < -2^(OUT_W-1), clamp to -2^(OUT_W-1) and set sat.
- The push into the FIFO occurs the cycle after the scale stage.
- Latency: the cic_vld sample edge is t; m_valid rises after edge t+2 when the FIFO was empty.

FIFO and stream:
- FIFO is first-word-fall-through; m_dat shows the head entry.
- Pop occurs when m_valid && m_ready.
- m_dat holds its value while m_valid=1 and m_ready=0.
- Push when the FIFO is full:
  - If a pop occurs in the same cycle, push and pop both happen and occupancy is unchanged.
  - Otherwise the new sample is dropped, ovf is set, and FIFO contents are unchanged.

Flags:
- ovf and sat remain set until clr_flags is asserted.
- If a set and clr_flags occur in the same cycle, the set wins.

Optional Feature:
- Macro: CIC_DEC_CTRL_ROUND_EN.
- Defined: the scale stage adds 2^(shift_reg-1) before the shift when shift_reg > 0 (round half up). Saturation is applied after rounding. The adder is IN_W+1 bits wide so no internal wrap occurs.
- Undefined: floor (truncation) only. No rounding adder is generated.

Test Plan:
- Settle discard: shift_cfg=0, en=1, cic_vld strobes every 64 cycles with cic_dat=1..8 -> SETTLE drops 1..5, m_dat emits 6, 7, 8 in order with m_ready=1; busy=1 throughout.
- Scaling: shift_cfg=19.
  - cic_dat=3·2^19+2^18 -> m_dat=3 (ROUND_EN: 4).
  - cic_dat=-(2^19+1) -> m_dat=-2 (ROUND_EN: -1).
  - sat stays 0.
- Saturation: shift_cfg=0.
  - cic_dat=2^34-1 -> m_dat=32767, sat=1.
  - cic_dat=-2^34 -> m_dat=-32768.
  - clr_flags pulse -> sat=0.
  - Oversize shift: shift_cfg=63 is clamped to 34.
- Overflow: m_ready=0 in RUN, 6 strobes with values 10..15 -> FIFO holds 10..13, ovf=1; m_ready=1 then pops 10, 11, 12, 13 and m_valid falls.
- Drain and stop: in RUN with 2 entries queued and m_ready=0, drop en -> DRAIN, busy=1, cic_rstn=1. Pop both -> IDLE, cic_rstn=0, busy=0. Re-raise en -> SETTLE again.
- Reset mid-operation: assert rstn=0 in RUN with a non-empty FIFO -> m_valid=0, cic_rstn=0, ovf=sat=0 immediately. After release, IDLE until en is asserted.
